// File: rtl/ula_sequencer.sv
// Multicycle control FSM for the register-file + SrcB mux + ULA datapath (IDLE/DECODE/EXECUTE/WRITEBACK).
// Optional feature: define SEQ_COND_SKIP_EN to suppress write-back when cond=1 and the prior zero_flag=1.
module ula_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [13:0]       instr,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              srcb_sel,
  output logic [DATA_W-1:0] srcb_imm,
  output logic [2:0]        ula_control,
  input  logic [DATA_W-1:0] ula_result,
  input  logic              ula_zero,
  output logic              busy,
  output logic              done,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  instr_count
);

`ifdef SEQ_COND_SKIP_EN
  localparam bit CondSkip = 1'b1;
`else
  localparam bit CondSkip = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXECUTE,
    WRITEBACK
  } state_e;

  state_e              state_q, state_d;
  logic [13:0]         instr_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                zero_q;
  logic                we_q;
  logic                done_q;
  logic                ready_q;
  logic                busy_q;
  logic [CNT_W-1:0]    count_q;
  logic                skip;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = instr_valid ? DECODE : IDLE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // zero_q still holds the previous instruction's flag when this is sampled at the EXECUTE edge
  assign skip = CondSkip && instr_q[13] && zero_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            imm_q   <= imm;
          end
        end
        EXECUTE: begin
          wdata_q <= ula_result;
          zero_q  <= ula_zero;
          we_q    <= !skip;
          done_q  <= 1'b1;
          count_q <= count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rf_addr1    = ADDR_W'(instr_q[5:3]);
  assign rf_addr2    = ADDR_W'(instr_q[2:0]);
  assign rf_waddr    = ADDR_W'(instr_q[8:6]);
  assign srcb_sel    = instr_q[9];
  assign ula_control = instr_q[12:10];
  assign srcb_imm    = imm_q;
  assign rf_wdata    = wdata_q;
  assign rf_we       = we_q;
  assign done        = done_q;
  assign zero_flag   = zero_q;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Randomized bench for ula_sequencer: an 8-entry register file and ULA surround the DUT,
// and an instruction-level reference model predicts each write-back, zero flag and count.
module tb_ula_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [13:0] instr;
  logic [7:0] imm;
  logic [2:0] rf_addr1, rf_addr2, rf_waddr;
  logic       rf_we;
  logic [7:0] rf_wdata;
  logic       srcb_sel;
  logic [7:0] srcb_imm;
  logic [2:0] ula_control;
  logic [7:0] ula_result;
  logic       ula_zero;
  logic       busy, done, zero_flag;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_sequencer #(.DATA_W(8), .ADDR_W(3), .CNT_W(8)) dut (
    .clock(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .srcb_sel(srcb_sel), .srcb_imm(srcb_imm),
    .ula_control(ula_control), .ula_result(ula_result), .ula_zero(ula_zero), .busy(busy),
    .done(done), .zero_flag(zero_flag), .instr_count(instr_count)
  );

  function automatic logic [7:0] ula(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {7'd0, (a < b)};
      default: return a ^ b;
    endcase
  endfunction

  // Surrounding datapath: register file written by the DUT, combinational ULA
  logic [7:0] env_rf [8];
  logic [7:0] tb_init [8];
  logic       tb_load = 1'b0;
  int         we_cnt = 0;

  always @(posedge clk) begin
    if (tb_load) env_rf <= tb_init;
    else if (rf_we) env_rf[rf_waddr] <= rf_wdata;
    if (rf_we) we_cnt++;
  end

  assign ula_result = ula(ula_control, env_rf[rf_addr1], srcb_sel ? srcb_imm : env_rf[rf_addr2]);
  assign ula_zero   = (ula_result == 8'd0);

  // Instruction-level reference state
  logic [7:0] ref_rf [8];
  logic       ref_zero;
  logic [7:0] ref_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check("rst_zero", 32'(zero_flag), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_addrs", {23'd0, rf_addr1, rf_addr2, rf_waddr}, 32'd0);
    check("rst_srcb", {23'd0, srcb_sel, srcb_imm}, 32'd0);
    check("rst_ctrl", 32'(ula_control), 32'd0);
    reset = 1'b0;
    ref_zero = 1'b0;
    ref_count = 8'd0;
  endtask

  task automatic run_instr(input logic [13:0] ins, input logic [7:0] im, input bit noise);
    logic [2:0] rd, rs1, rs2;
    logic [7:0] b, res;
    logic       z, we;
    int         we_before;
    rd  = ins[8:6];
    rs1 = ins[5:3];
    rs2 = ins[2:0];
    b   = ins[9] ? im : ref_rf[rs2];
    res = ula(ins[12:10], ref_rf[rs1], b);
    z   = (res == 8'd0);
`ifdef SEQ_COND_SKIP_EN
    we  = !(ins[13] && ref_zero);
`else
    we  = 1'b1;
`endif
    wait_ready();
    we_before = we_cnt;
    instr_valid = 1'b1;
    instr = ins;
    imm = im;
    tick();  // DECODE
    instr_valid = noise;
    instr = 14'($urandom);
    imm = 8'($urandom);
    check("dec_ready", 32'(instr_ready), 32'd0);
    check("dec_busy", 32'(busy), 32'd1);
    check("dec_addr1", 32'(rf_addr1), 32'(rs1));
    check("dec_addr2", 32'(rf_addr2), 32'(rs2));
    check("dec_waddr", 32'(rf_waddr), 32'(rd));
    check("dec_srcb_sel", 32'(srcb_sel), 32'(ins[9]));
    check("dec_srcb_imm", 32'(srcb_imm), 32'(im));
    check("dec_ctrl", 32'(ula_control), 32'(ins[12:10]));
    check("dec_we", 32'(rf_we), 32'd0);
    tick();  // EXECUTE
    check("ex_ready", 32'(instr_ready), 32'd0);
    check("ex_we", 32'(rf_we), 32'd0);
    check("ex_done", 32'(done), 32'd0);
    tick();  // WRITEBACK
    check("wb_ready", 32'(instr_ready), 32'd0);
    check("wb_we", 32'(rf_we), 32'(we));
    check("wb_done", 32'(done), 32'd1);
    check("wb_waddr", 32'(rf_waddr), 32'(rd));
    check("wb_wdata", 32'(rf_wdata), 32'(res));
    check("wb_zero", 32'(zero_flag), 32'(z));
    tick();  // IDLE
    instr_valid = 1'b0;
    if (we) ref_rf[rd] = res;
    ref_zero = z;
    ref_count++;
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_we", 32'(rf_we), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_hold_waddr", 32'(rf_waddr), 32'(rd));
    check("idle_count", 32'(instr_count), 32'(ref_count));
    check("we_pulses", 32'(we_cnt - we_before), 32'(we));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we_before;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    imm = '0;
    for (int i = 0; i < 8; i++) tb_init[i] = 8'($urandom);
    tb_init[1] = 8'd3;
    tb_init[2] = 8'd4;
    ref_rf = tb_init;
    tb_load = 1'b1;
    tick();
    tb_load = 1'b0;
    do_reset();

    // register op: r5 = r1 + r2 = 7
    run_instr({1'b0, 3'b010, 1'b0, 3'd5, 3'd1, 3'd2}, 8'h00, 1'b0);
    check("regop_r5", 32'(env_rf[5]), 32'h07);
    // immediate op: r6 = r1 + 7
    run_instr({1'b0, 3'b010, 1'b1, 3'd6, 3'd1, 3'd0}, 8'h07, 1'b0);
    // valid pulses while busy are dropped
    run_instr({1'b0, 3'b001, 1'b0, 3'd7, 3'd5, 3'd6}, 8'h5a, 1'b1);
    // zero-producing op, then conditional op
    run_instr({1'b0, 3'b110, 1'b0, 3'd3, 3'd2, 3'd2}, 8'h00, 1'b0);
    we_before = we_cnt;
    run_instr({1'b1, 3'b010, 1'b0, 3'd4, 3'd1, 3'd2}, 8'h00, 1'b0);
`ifdef SEQ_COND_SKIP_EN
    check("cond_skip_we", 32'(we_cnt - we_before), 32'd0);
`else
    check("cond_skip_we", 32'(we_cnt - we_before), 32'd1);
`endif

    for (int i = 0; i < 30; i++) run_instr(14'($urandom), 8'($urandom), 1'($urandom));

    // abort in EXECUTE
    wait_ready();
    we_before = we_cnt;
    instr_valid = 1'b1;
    instr = {1'b0, 3'b010, 1'b0, 3'd0, 3'd1, 3'd2};
    tick();
    instr_valid = 1'b0;
    tick();
    check("abort_in_ex_busy", 32'(busy), 32'd1);
    do_reset();
    check("abort_no_write", 32'(we_cnt - we_before), 32'd0);
    tick();
    check("abort_idle_ready", 32'(instr_ready), 32'd1);
    check("abort_we_after", 32'(we_cnt - we_before), 32'd0);

    // counter wrap after 256 instructions from reset
    for (int i = 0; i < 256; i++) run_instr(14'($urandom), 8'($urandom), 1'($urandom));
    check("count_wrap", 32'(instr_count), 32'd0);

    for (int i = 0; i < 8; i++) check("rf_final", 32'(env_rf[i]), 32'(ref_rf[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
